serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8: operand and sum width in bits, legal range 2..32.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 a  input  WIDTH  operand A, captured on accepted start.
REQ-006 b  input  WIDTH  operand B, captured on accepted start.
REQ-007 cin  input  1  carry-in, captured on accepted start.
REQ-008 busy  output  1  high while an addition is in progress (SHIFT state).
REQ-009 done  output  1  single-cycle pulse marking a new valid result.
REQ-010 sum  output  WIDTH  registered result (a+b+cin) mod 2^WIDTH.
REQ-011 cout  output  1  registered carry-out of the addition.

Function
REQ-012 FSM states: IDLE, SHIFT, DONE; encoding is free.
REQ-013 IDLE -> SHIFT when start=1: capture a, b into operand shift registers, cin into carry flop, clear bit counter.
REQ-014 IDLE with start=0: stay IDLE, no register changes.
REQ-015 SHIFT: each cycle one full-adder step on operand LSBs plus carry flop; sum bit shifts into MSB of internal result shift register; carry flop takes carry-out; operands shift right one; counter increments.
REQ-016 SHIFT -> DONE after exactly WIDTH SHIFT cycles (counter reaches WIDTH-1 and completes that step).
REQ-017 On SHIFT -> DONE transition: sum and cout output registers load the final result; done asserts for the DONE cycle only.
REQ-018 DONE -> IDLE unconditionally after one cycle.
REQ-019 Latency: start accepted at edge t -> done high in cycle t+WIDTH+1 (WIDTH+1 cycles after acceptance).
REQ-020 busy = 1 exactly in SHIFT; busy = 0 in IDLE and DONE.
REQ-021 start while SHIFT or DONE is ignored; no queuing; a, b, cin ignored outside the accepting edge.
REQ-022 sum and cout hold the previous result during a new computation and change only at done.
REQ-023 Operands changing after acceptance have no effect on the result.
REQ-024 Overflow: carry beyond bit WIDTH-1 appears only on cout; sum wraps modulo 2^WIDTH.

Reset
REQ-025 rst=1 at a rising edge forces IDLE, clears counter, carry flop, shift registers, sum=0, cout=0, busy=0, done=0.
REQ-026 rst mid-SHIFT aborts the addition; no done pulse follows.
REQ-027 rst has priority over start in the same cycle.
REQ-028 First start is accepted on the first edge with rst=0 and start=1.

Structure
REQ-029 Shared package holds the FSM state typedef and the default WIDTH constant.
REQ-030 One sub-module, fa_cell: combinational 1-bit full adder (a, b, cin -> sum, cout), instantiated once.
REQ-031 Counter width is clog2(WIDTH)+1; no other arithmetic operators on the datapath.

Verification (WIDTH=8)
REQ-032 a=0x00, b=0x00, cin=0, start -> done 9 cycles after acceptance, sum=0x00, cout=0; busy high 8 cycles.
REQ-033 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-034 a=0x5A, b=0xA5, cin=0 -> sum=0xFF, cout=0; sum/cout keep the previous result until this done.
REQ-035 start pulsed during SHIFT with different operands -> ignored; exactly one done, result of the first operands.
REQ-036 rst asserted 4 cycles into SHIFT -> next cycle IDLE, sum=0, cout=0, busy=0, no done; a new start then completes normally.
REQ-037 Exhaustive random sweep (all cin, 1000+ operand pairs, back-to-back starts issued in cycle after done) -> every result matches a+b+cin reference model.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
package serial_adder_pkg;

  // Controller states: wait for start, add one bit per cycle, present result.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Default operand/sum width.
  localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_adder_fa_cell.sv
// Combinational one-bit full adder used for each serial addition step.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  // Sum is the parity of the inputs; carry is their majority.
  always_comb begin
    sum  = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
  end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: adds two WIDTH-bit operands plus carry-in, LSB first,
// one bit per cycle, and registers the result when the last bit is done.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             fa_s, fa_co;

  fa_cell u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .sum  (fa_s),
    .cout (fa_co)
  );

  // Next-state and datapath control; result registers only move on the final step.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SHIFT;
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
        end
      end
      ST_SHIFT: begin
        res_d   = {fa_s, res_q[WIDTH-1:1]};
        carry_d = fa_co;
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
          sum_d   = res_d;
          cout_d  = fa_co;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  // Status flags decode directly from the registered state.
  always_comb begin
    busy = (state_q == ST_SHIFT);
    done = (state_q == ST_DONE);
    sum  = sum_q;
    cout = cout_q;
  end

endmodule

// File: tb/tb_serial_adder.sv
// Randomized self-checking bench for serial_adder (WIDTH=8).
module tb_serial_adder;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int errors = 0;
  int checks = 0;

  // Reference: last completed result as seen on the outputs.
  logic [W-1:0] m_sum  = '0;
  logic         m_cout = 1'b0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One addition from start to done; optionally pulse start with other
  // operands throughout SHIFT, which must be ignored.
  task automatic run_add(input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic ic, input bit disturb);
    logic [W:0] full;
    int k;
    full = {1'b0, ia} + {1'b0, ib} + {{W{1'b0}}, ic};
    @(negedge clk);
    rst = 1'b0; a = ia; b = ib; cin = ic; start = 1'b1;
    @(posedge clk); #1;
    start = disturb;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    k = 0;
    while (!done && k < 20) begin
      check("busy_in_shift", 32'(busy), 32'd1);
      check("sum_hold", 32'(sum), 32'(m_sum));
      check("cout_hold", 32'(cout), 32'(m_cout));
      @(posedge clk); #1;
      k++;
      if (disturb) begin
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      end
    end
    start = 1'b0;
    check("done_latency", 32'(k), 32'(W));
    check("sum", 32'(sum), 32'(full[W-1:0]));
    check("cout", 32'(cout), 32'(full[W]));
    check("busy_at_done", 32'(busy), 32'd0);
    m_sum  = full[W-1:0];
    m_cout = full[W];
    @(posedge clk); #1;
    check("done_single_pulse", 32'(done), 32'd0);
    check("idle_after_done", 32'(busy), 32'd0);
  endtask

  initial begin
    int dones;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    // rst wins over start in the same cycle
    @(negedge clk); start = 1'b1; a = 8'h12; b = 8'h34;
    @(posedge clk); #1;
    check("rst_over_start", 32'(busy), 32'd0);

    // first start accepted on the first edge with rst low
    run_add(8'h00, 8'h00, 1'b0, 1'b0);
    run_add(8'hFF, 8'h01, 1'b0, 1'b0);
    run_add(8'hFF, 8'hFF, 1'b1, 1'b0);
    run_add(8'h5A, 8'hA5, 1'b0, 1'b0);
    run_add(8'h33, 8'h44, 1'b1, 1'b1);

    // reset four cycles into SHIFT aborts with no done
    @(negedge clk); a = 8'hC3; b = 8'h7E; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("busy_before_abort", 32'(busy), 32'd1);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    m_sum = '0; m_cout = 1'b0;
    @(negedge clk); rst = 1'b0;
    dones = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("abort_no_done", 32'(dones), 32'd0);
    run_add(8'h80, 8'h80, 1'b1, 1'b0);

    // random sweep, back-to-back starts
    for (int i = 0; i < 1100; i++) begin
      run_add(W'($urandom), W'($urandom), 1'(i), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
